// File: rtl/cfg_pkt_pkg.sv
// Packet field layout, port opcodes and reset constants shared by config_controls_credit.
// Offsets are derived from the DEF_* widths; the top-level parameters default to the same values.
package cfg_pkt_pkg;

  localparam int DEF_PACKET_BITS   = 97;
  localparam int DEF_NUM_LEAF_BITS = 6;
  localparam int DEF_NUM_PORT_BITS = 4;
  localparam int DEF_NUM_ADDR_BITS = 7;
  localparam int DEF_PAYLOAD_BITS  = 64;
  localparam int DEF_NUM_IN_PORTS  = 7;
  localparam int DEF_NUM_OUT_PORTS = 7;
  localparam int DEF_IN_PORT_BASE  = 2;
  localparam int DEF_OUT_PORT_BASE = 9;

  localparam int FS_MAX = (1 << DEF_NUM_ADDR_BITS) - 1;

  // Header: {vld, leaf, port}; payload MSB first: {self_port, leaf, port, bram_addr, freespace, pad}
  localparam int VLD_POS   = DEF_PACKET_BITS - 1;
  localparam int LEAF_LSB  = VLD_POS - DEF_NUM_LEAF_BITS;
  localparam int PORT_LSB  = LEAF_LSB - DEF_NUM_PORT_BITS;
  localparam int SELF_LSB  = DEF_PAYLOAD_BITS - DEF_NUM_PORT_BITS;
  localparam int DLEAF_LSB = SELF_LSB - DEF_NUM_LEAF_BITS;
  localparam int DPORT_LSB = DLEAF_LSB - DEF_NUM_PORT_BITS;
  localparam int BRAM_LSB  = DPORT_LSB - DEF_NUM_ADDR_BITS;
  localparam int FS_LSB    = BRAM_LSB - DEF_NUM_ADDR_BITS;

  // Per-port register image widths: input {leaf, port}; output {leaf, port, bram, credit, 3 strobes}
  localparam int IN_REG_BITS  = DEF_NUM_LEAF_BITS + DEF_NUM_PORT_BITS;
  localparam int OUT_REG_BITS = DEF_NUM_LEAF_BITS + DEF_NUM_PORT_BITS + 2 * DEF_NUM_ADDR_BITS + 3;

  localparam logic [DEF_NUM_PORT_BITS-1:0] PORT_OUT_CFG  = 4'd0;
  localparam logic [DEF_NUM_PORT_BITS-1:0] PORT_IN_CFG   = 4'd1;
  localparam logic [DEF_NUM_PORT_BITS-1:0] PORT_READBACK = 4'd2;

  localparam logic [DEF_NUM_PORT_BITS-1:0] RST_SRC_PORT = 4'd9;
  localparam logic [DEF_NUM_PORT_BITS-1:0] RST_DST_PORT = 4'd2;

  typedef enum logic [1:0] {RB_IDLE, RB_LOAD, RB_HOLD} rb_state_t;

endpackage

// File: rtl/cfg_credit_counter.sv
// One output port's free-space credit: load beats everything, inc+dec cancel, saturating inc/dec.
module cfg_credit_counter
  import cfg_pkt_pkg::*;
#(
  parameter int W = DEF_NUM_ADDR_BITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] credit,
  output logic         stall,
  output logic         add_en
);

  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] credit_nxt;

  always_comb begin
    credit_nxt = credit;
    if (load) begin
      credit_nxt = load_val;
    end else if (inc && !dec) begin
      if (credit != '1) credit_nxt = credit + ONE;
    end else if (dec && !inc) begin
      if (credit != '0) credit_nxt = credit - ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit <= '1;
      stall  <= 1'b0;
      add_en <= 1'b0;
    end else begin
      credit <= credit_nxt;
      stall  <= (credit_nxt == '0);
      add_en <= inc && !load;
    end
  end

endmodule

// File: rtl/config_controls_credit.sv
// Configuration register bank with per-output credit counters and a readback response port.
// Optional malformed-packet counter is built only when CFG_ERR_CNT_EN is defined.
module config_controls_credit
  import cfg_pkt_pkg::*;
#(
  parameter int PACKET_BITS   = DEF_PACKET_BITS,
  parameter int NUM_LEAF_BITS = DEF_NUM_LEAF_BITS,
  parameter int NUM_PORT_BITS = DEF_NUM_PORT_BITS,
  parameter int NUM_ADDR_BITS = DEF_NUM_ADDR_BITS,
  parameter int PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
  parameter int NUM_IN_PORTS  = DEF_NUM_IN_PORTS,
  parameter int NUM_OUT_PORTS = DEF_NUM_OUT_PORTS,
  parameter int IN_PORT_BASE  = DEF_IN_PORT_BASE,
  parameter int OUT_PORT_BASE = DEF_OUT_PORT_BASE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PACKET_BITS-1:0]   configure_in,
  input  logic [NUM_OUT_PORTS-1:0] send_pulse,
  output logic [IN_REG_BITS*NUM_IN_PORTS+OUT_REG_BITS*NUM_OUT_PORTS-1:0] control_reg,
  output logic [NUM_OUT_PORTS-1:0] out_stall,
  output logic [PACKET_BITS-1:0]   rsp_packet,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rb_drop_cnt,
  output logic [7:0]               cfg_err_cnt
);

  localparam int IN_BITS = IN_REG_BITS * NUM_IN_PORTS;

  logic                     pkt_vld;
  logic [NUM_PORT_BITS-1:0] pkt_port, self_port, f_port;
  logic [NUM_LEAF_BITS-1:0] pkt_leaf, f_leaf;
  logic [NUM_ADDR_BITS-1:0] f_bram, f_fs;
  logic                     self_in_ok, self_out_ok;
  logic                     is_out_cfg, is_in_cfg, is_rb;
  logic                     unused_bits;

  assign pkt_vld   = configure_in[PACKET_BITS-1];
  assign pkt_leaf  = configure_in[LEAF_LSB +: NUM_LEAF_BITS];
  assign pkt_port  = configure_in[PORT_LSB +: NUM_PORT_BITS];
  assign self_port = configure_in[SELF_LSB +: NUM_PORT_BITS];
  assign f_leaf    = configure_in[DLEAF_LSB +: NUM_LEAF_BITS];
  assign f_port    = configure_in[DPORT_LSB +: NUM_PORT_BITS];
  assign f_bram    = configure_in[BRAM_LSB +: NUM_ADDR_BITS];
  assign f_fs      = configure_in[FS_LSB +: NUM_ADDR_BITS];
  assign unused_bits = ^{pkt_leaf, configure_in[PORT_LSB-1:PAYLOAD_BITS], configure_in[FS_LSB-1:1]};

  assign self_in_ok  = (int'(self_port) >= IN_PORT_BASE) && (int'(self_port) < IN_PORT_BASE + NUM_IN_PORTS);
  assign self_out_ok = (int'(self_port) >= OUT_PORT_BASE) && (int'(self_port) < OUT_PORT_BASE + NUM_OUT_PORTS);
  assign is_out_cfg  = pkt_vld && (pkt_port == PORT_OUT_CFG);
  assign is_in_cfg   = pkt_vld && (pkt_port == PORT_IN_CFG);
  assign is_rb       = pkt_vld && (pkt_port == PORT_READBACK);

  // Input port source registers; out-of-range self_port matches no index and is ignored
  logic [NUM_LEAF_BITS-1:0] src_leaf [NUM_IN_PORTS];
  logic [NUM_PORT_BITS-1:0] src_port [NUM_IN_PORTS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        src_leaf[i] <= '0;
        src_port[i] <= RST_SRC_PORT;
      end
    end else if (is_in_cfg) begin
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        if (int'(self_port) == IN_PORT_BASE + i) begin
          src_leaf[i] <= f_leaf;
          src_port[i] <= f_port;
        end
      end
    end
  end

  logic [NUM_LEAF_BITS-1:0] dst_leaf  [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dst_port  [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] bram_addr [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] credit    [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] out_wr, cr_inc, upd_fs_en, upd_bram_en, add_fs_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_fs_en   <= '0;
      upd_bram_en <= '0;
      for (int k = 0; k < NUM_OUT_PORTS; k++) begin
        dst_leaf[k]  <= '0;
        dst_port[k]  <= RST_DST_PORT;
        bram_addr[k] <= '0;
      end
    end else begin
      upd_fs_en   <= out_wr;
      upd_bram_en <= out_wr;
      for (int k = 0; k < NUM_OUT_PORTS; k++) begin
        if (out_wr[k]) begin
          dst_leaf[k]  <= f_leaf;
          dst_port[k]  <= f_port;
          bram_addr[k] <= f_bram;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    assign control_reg[i*IN_REG_BITS +: IN_REG_BITS] = {src_leaf[i], src_port[i]};
  end

  for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_out
    assign out_wr[k] = is_out_cfg && (int'(self_port) == OUT_PORT_BASE + k);
    assign cr_inc[k] = pkt_vld && (int'(pkt_port) == OUT_PORT_BASE + k) && configure_in[0];

    cfg_credit_counter #(.W(NUM_ADDR_BITS)) u_credit (
      .clk      (clk),
      .reset    (reset),
      .load     (out_wr[k]),
      .load_val (f_fs),
      .inc      (cr_inc[k]),
      .dec      (send_pulse[k]),
      .credit   (credit[k]),
      .stall    (out_stall[k]),
      .add_en   (add_fs_en[k])
    );

    assign control_reg[IN_BITS + k*OUT_REG_BITS +: OUT_REG_BITS] =
      {dst_leaf[k], dst_port[k], bram_addr[k], credit[k], upd_fs_en[k], upd_bram_en[k], add_fs_en[k]};
  end

  // Readback: IDLE captures the request, LOAD snapshots the stored config, HOLD presents it.
  // rsp_valid/rsp_ready: the response transfers on a cycle where both are 1; while rsp_valid
  // is 1 and rsp_ready is 0, rsp_packet holds steady.
  rb_state_t                rb_state, rb_state_nxt;
  logic [NUM_PORT_BITS-1:0] req_self, req_port;
  logic [NUM_LEAF_BITS-1:0] req_leaf;
  logic [NUM_LEAF_BITS-1:0] sel_leaf;
  logic [NUM_PORT_BITS-1:0] sel_port;
  logic [NUM_ADDR_BITS-1:0] sel_bram, sel_credit;
  logic [PACKET_BITS-1:0]   rsp_build;

  always_comb begin
    rb_state_nxt = rb_state;
    case (rb_state)
      RB_IDLE: if (is_rb && (self_in_ok || self_out_ok)) rb_state_nxt = RB_LOAD;
      RB_LOAD: rb_state_nxt = RB_HOLD;
      RB_HOLD: if (rsp_ready) rb_state_nxt = RB_IDLE;
      default: rb_state_nxt = RB_IDLE;
    endcase
  end

  always_comb begin
    sel_leaf   = '0;
    sel_port   = '0;
    sel_bram   = '0;
    sel_credit = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (int'(req_self) == IN_PORT_BASE + i) begin
        sel_leaf = src_leaf[i];
        sel_port = src_port[i];
      end
    end
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      if (int'(req_self) == OUT_PORT_BASE + k) begin
        sel_leaf   = dst_leaf[k];
        sel_port   = dst_port[k];
        sel_bram   = bram_addr[k];
        sel_credit = credit[k];
      end
    end
    rsp_build = '0;
    rsp_build[PACKET_BITS-1]                = 1'b1;
    rsp_build[LEAF_LSB +: NUM_LEAF_BITS]    = req_leaf;
    rsp_build[PORT_LSB +: NUM_PORT_BITS]    = req_port;
    rsp_build[SELF_LSB +: NUM_PORT_BITS]    = req_self;
    rsp_build[DLEAF_LSB +: NUM_LEAF_BITS]   = sel_leaf;
    rsp_build[DPORT_LSB +: NUM_PORT_BITS]   = sel_port;
    rsp_build[BRAM_LSB +: NUM_ADDR_BITS]    = sel_bram;
    rsp_build[FS_LSB +: NUM_ADDR_BITS]      = sel_credit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_state    <= RB_IDLE;
      req_self    <= '0;
      req_leaf    <= '0;
      req_port    <= '0;
      rsp_packet  <= '0;
      rb_drop_cnt <= '0;
    end else begin
      rb_state <= rb_state_nxt;
      if (rb_state == RB_IDLE && is_rb) begin
        req_self <= self_port;
        req_leaf <= f_leaf;
        req_port <= f_port;
      end
      if (rb_state == RB_LOAD) rsp_packet <= rsp_build;
      if (is_rb && rb_state != RB_IDLE && rb_drop_cnt != 8'hFF) rb_drop_cnt <= rb_drop_cnt + 8'd1;
    end
  end

  assign rsp_valid = (rb_state == RB_HOLD);

`ifdef CFG_ERR_CNT_EN
  logic bad_pkt;

  assign bad_pkt = pkt_vld && (
      (pkt_port == PORT_OUT_CFG && !self_out_ok) ||
      (pkt_port == PORT_IN_CFG && !self_in_ok) ||
      (pkt_port == PORT_READBACK && !(self_in_ok || self_out_ok)) ||
      (int'(pkt_port) > int'(PORT_READBACK) && int'(pkt_port) < OUT_PORT_BASE) ||
      (int'(pkt_port) >= OUT_PORT_BASE + NUM_OUT_PORTS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cfg_err_cnt <= '0;
    else if (bad_pkt && cfg_err_cnt != 8'hFF) cfg_err_cnt <= cfg_err_cnt + 8'd1;
  end
`else
  assign cfg_err_cnt = '0;
`endif

endmodule

// File: tb/tb_config_controls_credit.sv
// Directed bench for config_controls_credit: register writes, credit counters, readback handshake.
module tb_config_controls_credit;

  logic         clk = 1'b0;
  logic         reset;
  logic [96:0]  configure_in;
  logic [6:0]   send_pulse;
  logic [258:0] control_reg;
  logic [6:0]   out_stall;
  logic [96:0]  rsp_packet;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [7:0]   rb_drop_cnt;
  logic [7:0]   cfg_err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_err;

  always #5 clk = ~clk;

  config_controls_credit dut (
    .clk          (clk),
    .reset        (reset),
    .configure_in (configure_in),
    .send_pulse   (send_pulse),
    .control_reg  (control_reg),
    .out_stall    (out_stall),
    .rsp_packet   (rsp_packet),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rb_drop_cnt  (rb_drop_cnt),
    .cfg_err_cnt  (cfg_err_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [96:0] mk_pkt(input logic [3:0] port, input logic [3:0] self_p,
                                         input logic [5:0] l, input logic [3:0] p,
                                         input logic [6:0] b, input logic [6:0] f);
    logic [96:0] v;
    v = '0;
    v[96] = 1'b1;
    v[89:86] = port;
    v[63:60] = self_p;
    v[59:54] = l;
    v[53:50] = p;
    v[49:43] = b;
    v[42:36] = f;
    return v;
  endfunction

  function automatic logic [96:0] cr_pkt(input logic [3:0] port);
    logic [96:0] v;
    v = '0;
    v[96] = 1'b1;
    v[89:86] = port;
    v[0] = 1'b1;
    return v;
  endfunction

  function automatic logic [96:0] mk_rsp(input logic [5:0] hl, input logic [3:0] hp,
                                         input logic [3:0] self_p, input logic [5:0] l,
                                         input logic [3:0] p, input logic [6:0] b,
                                         input logic [6:0] c);
    logic [96:0] v;
    v = '0;
    v[96] = 1'b1;
    v[95:90] = hl;
    v[89:86] = hp;
    v[63:60] = self_p;
    v[59:54] = l;
    v[53:50] = p;
    v[49:43] = b;
    v[42:36] = c;
    return v;
  endfunction

  function automatic logic [26:0] mk_ofld(input logic [5:0] l, input logic [3:0] p,
                                          input logic [6:0] b, input logic [6:0] c,
                                          input logic ufs, input logic ubr, input logic add);
    return {l, p, b, c, ufs, ubr, add};
  endfunction

  function automatic logic [26:0] ofld(input int k);
    return control_reg[70 + k*27 +: 27];
  endfunction

  function automatic logic [9:0] ifld(input int i);
    return control_reg[i*10 +: 10];
  endfunction

  function automatic logic [6:0] cred(input int k);
    return control_reg[70 + k*27 + 3 +: 7];
  endfunction

  function automatic logic add_en(input int k);
    return control_reg[70 + k*27];
  endfunction

  initial begin
    reset = 1'b1;
    configure_in = '0;
    send_pulse = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step();

    // Reset image
    for (int k = 0; k < 7; k++) check("rst_out_reg", ofld(k), mk_ofld(6'd0, 4'd2, 7'd0, 7'd127, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 7; i++) check("rst_in_reg", ifld(i), {6'd0, 4'd9});
    check("rst_stall", out_stall, 7'd0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_packet", rsp_packet, 97'd0);
    check("rst_drop_cnt", rb_drop_cnt, 8'd0);
    check("rst_err_cnt", cfg_err_cnt, 8'd0);

    // Output config write to self_port 10 (output port 1)
    configure_in = mk_pkt(4'd0, 4'd10, 6'd5, 4'd3, 7'd4, 7'd3);
    step();
    configure_in = '0;
    check("out_wr_fields", ofld(1), mk_ofld(6'd5, 4'd3, 7'd4, 7'd3, 1'b1, 1'b1, 1'b0));
    check("out_wr_other_port", ofld(0), mk_ofld(6'd0, 4'd2, 7'd0, 7'd127, 1'b0, 1'b0, 1'b0));
    step();
    check("out_wr_strobe_drop", ofld(1), mk_ofld(6'd5, 4'd3, 7'd4, 7'd3, 1'b0, 1'b0, 1'b0));

    // Port 0 credit 3, drain to zero and saturate, then credit return
    configure_in = mk_pkt(4'd0, 4'd9, 6'd0, 4'd2, 7'd0, 7'd3);
    step();
    configure_in = '0;
    check("p0_load", cred(0), 7'd3);
    send_pulse = 7'b0000001;
    for (int j = 0; j < 4; j++) begin
      step();
      check("p0_dec_credit", cred(0), (j < 3) ? 2 - j : 0);
      check("p0_dec_stall", out_stall, (j >= 2) ? 7'b0000001 : 7'b0000000);
    end
    send_pulse = '0;
    configure_in = cr_pkt(4'd9);
    step();
    configure_in = '0;
    check("p0_return_credit", cred(0), 7'd1);
    check("p0_return_stall", out_stall, 7'd0);
    check("p0_add_en_pulse", add_en(0), 1'b1);
    step();
    check("p0_add_en_clear", add_en(0), 1'b0);

    // Port 2 (self 11): inc+dec at max, inc alone at max, load beats dec
    configure_in = cr_pkt(4'd11);
    send_pulse = 7'b0000100;
    step();
    configure_in = '0;
    send_pulse = '0;
    check("p2_incdec_max", cred(2), 7'd127);
    configure_in = cr_pkt(4'd11);
    step();
    configure_in = '0;
    check("p2_inc_sat", cred(2), 7'd127);
    configure_in = mk_pkt(4'd0, 4'd11, 6'd1, 4'd1, 7'd1, 7'd50);
    send_pulse = 7'b0000100;
    step();
    configure_in = '0;
    check("p2_load_beats_dec", cred(2), 7'd50);
    step();
    send_pulse = '0;
    check("p2_dec_alone", cred(2), 7'd49);
    configure_in = cr_pkt(4'd11);
    send_pulse = 7'b0000100;
    step();
    configure_in = '0;
    send_pulse = '0;
    check("p2_incdec_mid", cred(2), 7'd49);

    // Input config write to self 3 (input port 1), then read it back with rsp_ready low
    configure_in = mk_pkt(4'd1, 4'd3, 6'd7, 4'd12, 7'd0, 7'd0);
    step();
    configure_in = '0;
    check("in_wr_fields", ifld(1), {6'd7, 4'd12});
    configure_in = mk_pkt(4'd2, 4'd3, 6'd33, 4'd6, 7'd0, 7'd0);
    step();
    configure_in = '0;
    check("rb_lat_cycle1", rsp_valid, 1'b0);
    step();
    check("rb_lat_cycle2", rsp_valid, 1'b1);
    check("rb_in_packet", rsp_packet, mk_rsp(6'd33, 4'd6, 4'd3, 6'd7, 4'd12, 7'd0, 7'd0));
    configure_in = mk_pkt(4'd2, 4'd9, 6'd1, 4'd1, 7'd0, 7'd0);
    step();
    configure_in = '0;
    check("rb_drop_cnt", rb_drop_cnt, 8'd1);
    check("rb_hold_valid", rsp_valid, 1'b1);
    configure_in = mk_pkt(4'd1, 4'd3, 6'd1, 4'd1, 7'd0, 7'd0);
    step();
    configure_in = '0;
    check("rb_in_rewrite", ifld(1), {6'd1, 4'd1});
    for (int j = 0; j < 3; j++) begin
      check("rb_hold_packet", rsp_packet, mk_rsp(6'd33, 4'd6, 4'd3, 6'd7, 4'd12, 7'd0, 7'd0));
      check("rb_hold_valid", rsp_valid, 1'b1);
      if (j < 2) step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rb_release", rsp_valid, 1'b0);

    // Readback of output port 1 (self 10)
    configure_in = mk_pkt(4'd2, 4'd10, 6'd20, 4'd4, 7'd0, 7'd0);
    rsp_ready = 1'b1;
    step();
    configure_in = '0;
    step();
    check("rb_out_valid", rsp_valid, 1'b1);
    check("rb_out_packet", rsp_packet, mk_rsp(6'd20, 4'd4, 4'd10, 6'd5, 4'd3, 7'd4, 7'd3));
    step();
    rsp_ready = 1'b0;
    check("rb_out_release", rsp_valid, 1'b0);

    // Readback with out-of-range self_port gives no response
    configure_in = mk_pkt(4'd2, 4'd0, 6'd3, 4'd3, 7'd0, 7'd0);
    step();
    configure_in = '0;
    step();
    step();
    check("rb_bad_self_valid", rsp_valid, 1'b0);
    check("rb_bad_self_drop", rb_drop_cnt, 8'd1);

    // Malformed packets: port 5, and input write with self_port 12
    configure_in = mk_pkt(4'd5, 4'd3, 6'd9, 4'd9, 7'd9, 7'd9);
    step();
    configure_in = mk_pkt(4'd1, 4'd12, 6'd9, 4'd9, 7'd0, 7'd0);
    step();
    configure_in = '0;
    check("err_in_port1_kept", ifld(1), {6'd1, 4'd1});
    check("err_in_port0_kept", ifld(0), {6'd0, 4'd9});
    check("err_out_port3_kept", ofld(3), mk_ofld(6'd0, 4'd2, 7'd0, 7'd127, 1'b0, 1'b0, 1'b0));
`ifdef CFG_ERR_CNT_EN
    exp_err = 3;
`else
    exp_err = 0;
`endif
    check("err_cnt", cfg_err_cnt, exp_err);

    // Asynchronous reset during HOLD drops rsp_valid without a clock edge
    configure_in = mk_pkt(4'd2, 4'd3, 6'd2, 4'd2, 7'd0, 7'd0);
    step();
    configure_in = '0;
    step();
    check("areset_pre_valid", rsp_valid, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("areset_valid_drop", rsp_valid, 1'b0);
    check("areset_drop_cnt", rb_drop_cnt, 8'd0);
    step();
    reset = 1'b0;
    step();
    check("areset_idle", rsp_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/config_controls_credit.md
Name: config_controls_credit

Overview:
- Parametrised successor to the leaf configuration register bank.
- Decodes configuration packets from the network into per-input-port source registers and per-output-port destination/BRAM-address registers.
- Adds a live per-output-port free-space credit counter: decremented by local sends, incremented by credit-return packets, reloaded by configuration.
- Adds a readback path that returns any port's stored configuration as a response packet over a valid/ready handshake.

Parameters:
- PACKET_BITS, 97, total packet width; bit [PACKET_BITS-1] is the valid bit.
- NUM_LEAF_BITS, 6, leaf address width.
- NUM_PORT_BITS, 4, port address width.
- NUM_ADDR_BITS, 7, BRAM address and free-space width.
- PAYLOAD_BITS, 64, payload field width, in packet bits [PAYLOAD_BITS-1:0].
- NUM_IN_PORTS, 7, input port count; self_port ids IN_PORT_BASE..IN_PORT_BASE+NUM_IN_PORTS-1.
- NUM_OUT_PORTS, 7, output port count; self_port ids OUT_PORT_BASE..OUT_PORT_BASE+NUM_OUT_PORTS-1.
- IN_PORT_BASE, 2, first input port id.
- OUT_PORT_BASE, 9, first output port id; also the first credit-return packet port.
- Derived: FS_MAX = 2^NUM_ADDR_BITS-1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- configure_in  in  PACKET_BITS  configuration/credit packet; sampled every cycle the valid bit is 1.
- send_pulse  in  NUM_OUT_PORTS  bit k=1: output port k consumed one slot this cycle.
- control_reg  out  IN_REG_BITS*NUM_IN_PORTS + OUT_REG_BITS*NUM_OUT_PORTS  flat register image, same packing as the current bank, port 0 in LSBs.
- out_stall  out  NUM_OUT_PORTS  bit k=1 when credit[k]==0.
- rsp_packet  out  PACKET_BITS  readback response packet.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rb_drop_cnt  out  8  count of readback requests dropped while busy; saturates at 255.
- cfg_err_cnt  out  8  malformed-packet counter; see Optional Feature.

Behaviour:
- Packet header fields: vld = bit [PACKET_BITS-1]; leaf and port follow, MSB first.
- Payload fields, MSB first: self_port, dst_src_leaf, dst_src_port, bram_addr, freespace.
- Packet port values:
  - port==0: output config write.
  - port==1: input config write.
  - port==2: readback request.
  - port in OUT_PORT_BASE+k: credit return to output port k; the increment is payload[0].
- Reset values:
  - src_leaf=0, src_port=9.
  - dst_leaf=0, dst_port=2, bram_addr=0, credit=FS_MAX.
  - update/add strobes 0, out_stall=0.
  - rsp_valid=0, rsp_packet=0, counters 0, FSM in IDLE.
- Config writes:
  - Registered; visible in control_reg one cycle after the packet.
  - A write whose self_port is out of range is ignored.
- Output config write:
  - Loads dst_leaf, dst_port, bram_addr and credit := freespace field.
  - Pulses update_freespace_en and update_bram_addr_en for exactly one cycle.
- Credit counter k, priority order:
  - Config load beats everything.
  - Increment and decrement in the same cycle: no change.
  - Increment alone saturates at FS_MAX.
  - Decrement alone saturates at 0.
  - add_freespace_en[k] is a one-cycle registered copy of the applied increment.
- Per-port control_reg field order is the existing one, with credit in the freespace position; out_stall is registered.
- Readback FSM: IDLE -> LOAD -> HOLD -> IDLE.
  - IDLE: a readback request with valid self_port moves to LOAD.
  - LOAD (1 cycle): builds rsp_packet.
    - vld=1, leaf=dst_src_leaf of the request, port=dst_src_port of the request.
    - Payload = {self_port, stored leaf, stored port, bram_addr (0 for input ports), credit (0 for input ports), zero pad}.
  - HOLD: rsp_valid=1 and rsp_packet stable until rsp_ready=1, then back to IDLE.
  - Latency from request to first rsp_valid: 2 cycles.
  - A request arriving outside IDLE is dropped and increments rb_drop_cnt.
  - A request with out-of-range self_port returns to IDLE with no response.
  - Response data is a snapshot taken in LOAD; later writes do not alter a held response.
- Reset asserted mid-handshake: rsp_valid drops immediately (asynchronous); the response is lost.

Optional Feature:
- Macro CFG_ERR_CNT_EN.
- Defined: cfg_err_cnt increments (saturating at 255) on each valid packet that is one of:
  - port 0, 1 or 2 with out-of-range self_port;
  - port in 3..OUT_PORT_BASE-1;
  - port >= OUT_PORT_BASE+NUM_OUT_PORTS.
- Undefined: cfg_err_cnt tied to 0 and no counter logic is built.

Decomposition:
- Package cfg_pkt_pkg holds:
  - field offset/width localparams derived from the parameters;
  - port opcode constants: PORT_OUT_CFG=0, PORT_IN_CFG=1, PORT_READBACK=2;
  - reset constants (src_port 9, dst_port 2).
- Sub-module cfg_credit_counter holds one output port's counter: saturating inc/dec, load priority and stall flag. It is instantiated NUM_OUT_PORTS times in a generate loop.

Test Plan:
- Reset, then idle -> control_reg shows src_port=9, dst_port=2, credit=127 on every port; out_stall=0; rsp_valid=0.
- Output config write self_port=10, leaf 5, dst_port 3, bram 4, freespace 3 -> next cycle port 1 fields = 5/3/4/3 and the update strobes are high for exactly one cycle.
- Port 0 with credit 3: three send_pulse cycles -> credit 0 and out_stall=1. A fourth pulse -> credit stays 0. Credit-return packet on port 9 with payload[0]=1 -> credit 1, out_stall=0.
- Credit 127 with inc+dec in the same cycle -> 127. Inc alone -> stays 127. Config load plus send_pulse in the same cycle -> loaded value.
- Readback of self_port=3 with rsp_ready held low 5 cycles -> rsp_valid high from cycle 2, packet stable. A second request during HOLD -> rb_drop_cnt=1. rsp_ready=1 -> rsp_valid low next cycle.
- With CFG_ERR_CNT_EN defined: packets on port 5 and port 1 with self_port=12 -> cfg_err_cnt=2 and registers unchanged. Without the macro -> cfg_err_cnt stays 0.
